// File: rtl/rv0_csr_access.sv
// rv0_csr_access: Zicsr read-modify-write sequencer between execute and the CSR file
module rv0_csr_access #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic            req_imm_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [4:0]      req_zimm_i,
    input  logic            req_rd_zero_i,
    input  logic [11:0]     req_addr_i,
    input  logic [1:0]      req_priv_i,
    output logic            csr_re_o,
    output logic            csr_we_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic            csr_err_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_illegal_o
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_WR, S_RESP} state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    state_t          r_state;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_opnd;
    logic [11:0]     r_addr;
    logic            r_do_wr;
    logic [XLEN-1:0] r_old;
    logic            r_illegal;

    logic            w_accept;
    logic [XLEN-1:0] w_opnd;
    logic            w_do_rd;
    logic            w_do_wr;
    logic            w_pre_ill;
    logic [XLEN-1:0] w_wdata;

    assign w_accept  = req_valid_i && req_ready_o;
    assign w_opnd    = req_imm_i ? {{(XLEN-5){1'b0}}, req_zimm_i} : req_rs1_i;
    assign w_do_rd   = !(req_op_i == OP_RW && req_rd_zero_i);
    assign w_do_wr   = (req_op_i == OP_RW) || (req_zimm_i != 5'd0);
    assign w_pre_ill = (req_op_i == 2'b00) || (req_addr_i[9:8] > req_priv_i) ||
                       (req_addr_i[11:10] == 2'b11 && w_do_wr);
    assign w_wdata   = (r_op == OP_RW) ? r_opnd :
                       (r_op == OP_RS) ? (r_old | r_opnd) : (r_old & ~r_opnd);

    // Sequencer: latch the request, walk read/write phases, hold the response until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_op      <= 2'b00;
            r_opnd    <= '0;
            r_addr    <= '0;
            r_do_wr   <= 1'b0;
            r_old     <= '0;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op      <= req_op_i;
                    r_opnd    <= w_opnd;
                    r_addr    <= req_addr_i;
                    r_do_wr   <= w_do_wr;
                    r_old     <= '0;
                    r_illegal <= w_pre_ill;
                    r_state   <= w_pre_ill ? S_RESP : (w_do_rd ? S_RD : S_WR);
                end
                S_RD:  r_state <= S_RDW;
                S_RDW: begin
                    r_old     <= csr_rdata_i;
                    r_illegal <= csr_err_i;
                    r_state   <= (csr_err_i || !r_do_wr) ? S_RESP : S_WR;
                end
                S_WR: begin
                    r_illegal <= csr_err_i;
                    r_state   <= S_RESP;
                end
                S_RESP: if (rsp_ready_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o   = (r_state == S_IDLE) && !flush_i;
    assign csr_re_o      = (r_state == S_RD);
    assign csr_we_o      = (r_state == S_WR);
    assign csr_addr_o    = (csr_re_o || csr_we_o) ? r_addr : 12'h000;
    assign csr_wdata_o   = csr_we_o ? w_wdata : '0;
    assign rsp_valid_o   = (r_state == S_RESP);
    assign rsp_illegal_o = rsp_valid_o && r_illegal;
    assign rsp_rdata_o   = (rsp_valid_o && !r_illegal) ? r_old : '0;
endmodule

// File: tb/tb_rv0_csr_access.sv
// tb_rv0_csr_access: scoreboard bench with a behavioural CSR file behind the DUT
module tb_rv0_csr_access;
    localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

    logic        clk = 0, rst_ni = 0, flush_i = 0, req_valid_i = 0, rsp_ready_i = 1;
    logic        req_ready_o, req_imm_i = 0, req_rd_zero_i = 0;
    logic [1:0]  req_op_i = 0, req_priv_i = 0;
    logic [31:0] req_rs1_i = 0;
    logic [4:0]  req_zimm_i = 0;
    logic [11:0] req_addr_i = 0;
    logic        csr_re_o, csr_we_o, csr_err_i, rsp_valid_o, rsp_illegal_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o, csr_rdata_i, rsp_rdata_o;

    rv0_csr_access #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_imm_i(req_imm_i), .req_rs1_i(req_rs1_i), .req_zimm_i(req_zimm_i),
        .req_rd_zero_i(req_rd_zero_i), .req_addr_i(req_addr_i), .req_priv_i(req_priv_i),
        .csr_re_o(csr_re_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i), .csr_err_i(csr_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_illegal_o(rsp_illegal_o)
    );

    always #5 clk = ~clk;

    // CSR file model: 0x7FF is unimplemented, everything else is storage
    logic [31:0] mem [0:4095];
    logic        init = 1, re_d = 0;
    logic [11:0] a_d = 0;
    function automatic logic unimpl(input logic [11:0] a);
        return a == 12'h7FF;
    endfunction
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[12'h300] <= 32'h1800;
            mem[12'hF14] <= 32'h3;
            mem[12'h100] <= 32'h22;
        end else if (csr_we_o && !unimpl(csr_addr_o)) mem[csr_addr_o] <= csr_wdata_o;
        re_d        <= csr_re_o;
        a_d         <= csr_addr_o;
        csr_rdata_i <= csr_re_o ? mem[csr_addr_o] : 32'h0;
    end
    assign csr_err_i = (re_d && unimpl(a_d)) || (csr_we_o && unimpl(csr_addr_o));

    typedef struct {logic [31:0] rdata; logic ill; int lat;} rsp_t;
    typedef struct {logic [11:0] addr; logic [31:0] data;} wr_t;
    rsp_t        rsp_q[$];
    wr_t         we_q[$];
    logic [11:0] re_q[$];
    int          n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
    bit          first = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every strobe and every response cycle against the scoreboard
    always @(negedge clk) if (rst_ni) begin
        if (req_valid_i && req_ready_o) acc_cyc = cyc;
        if (csr_re_o && csr_we_o) unexpected("re_we_together");
        if (csr_re_o) begin
            if (re_q.size() == 0) unexpected("re");
            else check("re_addr", {20'h0, csr_addr_o}, {20'h0, re_q.pop_front()});
        end
        if (csr_we_o) begin
            if (we_q.size() == 0) unexpected("we");
            else begin
                check("we_addr", {20'h0, csr_addr_o}, {20'h0, we_q[0].addr});
                check("we_data", csr_wdata_o, we_q[0].data);
                void'(we_q.pop_front());
            end
        end
        if (rsp_valid_o) begin
            if (rsp_q.size() == 0) unexpected("rsp");
            else begin
                check("rsp_rdata", rsp_rdata_o, rsp_q[0].rdata);
                check("rsp_illegal", {31'h0, rsp_illegal_o}, {31'h0, rsp_q[0].ill});
                if (first) check("rsp_latency", cyc - acc_cyc, rsp_q[0].lat);
                first = 0;
                if (rsp_ready_i) begin
                    void'(rsp_q.pop_front());
                    first = 1;
                end
            end
        end
    end

    task automatic exp_rsp(input logic [31:0] d, input logic ill, input int lat);
        rsp_t r;
        r.rdata = d; r.ill = ill; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic exp_we(input logic [11:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        we_q.push_back(w);
    endtask

    task automatic issue(input logic [1:0] op, input logic imm, input logic [31:0] rs1,
                         input logic [4:0] zimm, input logic rdz, input logic [11:0] addr,
                         input logic [1:0] priv);
        bit ok = 0;
        req_op_i = op; req_imm_i = imm; req_rs1_i = rs1; req_zimm_i = zimm;
        req_rd_zero_i = rdz; req_addr_i = addr; req_priv_i = priv; req_valid_i = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready_o;
        end
        if (!ok) unexpected("accept_timeout");
        @(posedge clk);
        #1 req_valid_i = 0;
    endtask

    task automatic drain;
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1 done = rsp_q.size() == 0 && we_q.size() == 0 && re_q.size() == 0 && !rsp_valid_o;
        end
        if (!done) unexpected("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] op, input logic imm, input logic [31:0] rs1,
                       input logic [4:0] zimm, input logic rdz, input logic [11:0] addr,
                       input logic [1:0] priv);
        issue(op, imm, rs1, zimm, rdz, addr, priv);
        drain();
    endtask

    initial begin
        bit seen = 0;
        #1;
        check("reset_ready", {31'h0, req_ready_o}, 32'h1);
        check("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("reset_strobes", {30'h0, csr_re_o, csr_we_o}, 32'h0);
        check("reset_rdata", rsp_rdata_o, 32'h0);
        repeat (2) @(posedge clk);
        #1 init = 0; rst_ni = 1;
        @(posedge clk);
        #1;
        re_q.push_back(12'h300); exp_we(12'h300, 32'h1808); exp_rsp(32'h1800, 0, 4);
        run(RS, 0, 32'h8, 5'd1, 0, 12'h300, 2'b11);
        exp_we(12'h305, 32'h100); exp_rsp(32'h0, 0, 2);
        run(RW, 0, 32'h100, 5'd2, 1, 12'h305, 2'b11);
        re_q.push_back(12'hF14); exp_rsp(32'h3, 0, 3);
        run(RC, 1, 32'hFFFF, 5'd0, 0, 12'hF14, 2'b11);
        exp_rsp(32'h0, 1, 1);
        run(RW, 0, 32'h1, 5'd1, 0, 12'hF11, 2'b11);
        exp_rsp(32'h0, 1, 1);
        run(RW, 0, 32'h1, 5'd1, 0, 12'h300, 2'b00);
        exp_rsp(32'h0, 1, 1);
        run(2'b00, 0, 32'h1, 5'd1, 0, 12'h300, 2'b11);
        rsp_ready_i = 0;
        re_q.push_back(12'h7FF); exp_rsp(32'h0, 1, 3);
        issue(RS, 0, 32'hF, 5'd5, 0, 12'h7FF, 2'b11);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid_o;
        end
        if (!seen) unexpected("rsp_timeout");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready_i = 1;
        drain();
        re_q.push_back(12'h300); exp_we(12'h300, 32'h1800); exp_rsp(32'h1808, 0, 4);
        run(RC, 0, 32'h8, 5'd1, 0, 12'h300, 2'b11);
        re_q.push_back(12'h300); exp_we(12'h300, 32'h1804); exp_rsp(32'h1800, 0, 4);
        run(RS, 1, 32'h0, 5'd4, 0, 12'h300, 2'b11);
        exp_rsp(32'h0, 1, 1);
        run(RS, 0, 32'h0, 5'd0, 0, 12'h100, 2'b00);
        re_q.push_back(12'h100); exp_rsp(32'h22, 0, 3);
        run(RS, 0, 32'h0, 5'd0, 0, 12'h100, 2'b01);
        exp_we(12'h7FF, 32'h55); exp_rsp(32'h0, 1, 2);
        run(RW, 0, 32'h55, 5'd3, 1, 12'h7FF, 2'b11);
        exp_rsp(32'h0, 1, 1);
        run(RS, 0, 32'h1, 5'd3, 0, 12'hF11, 2'b11);
        flush_i = 1; req_valid_i = 1;
        @(negedge clk);
        check("flush_idle_ready", {31'h0, req_ready_o}, 32'h0);
        @(posedge clk);
        #1 flush_i = 0; req_valid_i = 0;
        re_q.push_back(12'h305); exp_we(12'h305, 32'h7); exp_rsp(32'h100, 0, 4);
        run(RW, 0, 32'h7, 5'd1, 0, 12'h305, 2'b11);
        re_q.push_back(12'h300);
        issue(RS, 0, 32'h1, 5'd1, 0, 12'h300, 2'b11);
        flush_i = 1;
        @(posedge clk);
        #1 flush_i = 0;
        drain();
        re_q.push_back(12'h300); exp_rsp(32'h1804, 0, 3);
        run(RS, 0, 32'h0, 5'd0, 0, 12'h300, 2'b11);
        re_q.push_back(12'h300);
        issue(RS, 0, 32'h2, 5'd1, 0, 12'h300, 2'b11);
        @(posedge clk);
        #1 rst_ni = 0;
        #1;
        check("rst_mid_ready", {31'h0, req_ready_o}, 32'h1);
        check("rst_mid_strobes", {30'h0, csr_re_o, csr_we_o}, 32'h0);
        check("rst_mid_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        @(posedge clk);
        #1 rst_ni = 1;
        drain();
        re_q.push_back(12'h305); exp_rsp(32'h7, 0, 3);
        run(RS, 1, 32'h0, 5'd0, 0, 12'h305, 2'b11);
        re_q.push_back(12'h300); exp_rsp(32'h1804, 0, 3);
        run(RC, 1, 32'h0, 5'd0, 0, 12'h300, 2'b11);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
